// File: rtl/qspi_flash_responder_if.sv
// qspi_flash_responder_if: flash pad bundle plus the synchronous byte-wide memory port
interface qspi_flash_responder_if #(
    parameter int MEM_AW = 12
);
    logic              flash_csb;
    logic              flash_clk;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              cont_mode;
    logic              active;

    // Controller/memory side: drives the flash bus and returns memory data
    modport master (
        output flash_csb, flash_clk, io_in, mem_rdata,
        input  io_out, io_oe, mem_addr, mem_rd, cont_mode, active
    );

    // Responder side
    modport slave (
        input  flash_csb, flash_clk, io_in, mem_rdata,
        output io_out, io_oe, mem_addr, mem_rd, cont_mode, active
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: oversampled SPI/QSPI flash target serving 0x03/0xEB reads from a byte memory
module qspi_flash_responder #(
    parameter int MEM_AW    = 12,
    parameter int DUMMY_QIO = 4
) (
    input logic                   clock,
    input logic                   resetb,
    qspi_flash_responder_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_MODE  = 3'd3;
    localparam logic [2:0] S_DUMMY = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_IGN   = 3'd6;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_QIO > 0 ? DUMMY_QIO - 1 : 0);

    logic [1:0]        csb_sync_q;
    logic [2:0]        clk_sync_q;
    logic [3:0]        io_s1_q, io_s2_q;
    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [23:0]       sr_q, sr_d;
    logic              quad_q, quad_d;
    logic              cont_q, cont_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [3:0]        out_q, out_d;
    logic [3:0]        oe_q, oe_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic              rvalid_q;
    logic [7:0]        buf_q;

    logic              csb, rise, fall;
    logic [23:0]       shin;
    logic [7:0]        byte_v;
    logic [2:0]        bcnt_last;
    logic              addr_last;

    assign csb       = csb_sync_q[1];
    assign rise      = clk_sync_q[1] & ~clk_sync_q[2];
    assign fall      = ~clk_sync_q[1] & clk_sync_q[2];
    assign shin      = quad_q ? {sr_q[19:0], io_s2_q} : {sr_q[22:0], io_s2_q[0]};
    assign byte_v    = (bcnt_q == 3'd0) ? buf_q : sh_q;
    assign bcnt_last = quad_q ? 3'd1 : 3'd7;
    assign addr_last = cnt_q == (quad_q ? 8'd5 : 8'd23);

    // Two-flop synchronizers; io follows the same depth so data stays aligned with the clock edge
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            csb_sync_q <= 2'b11;
            clk_sync_q <= 3'b000;
            io_s1_q    <= 4'h0;
            io_s2_q    <= 4'h0;
        end else begin
            csb_sync_q <= {csb_sync_q[0], bus.flash_csb};
            clk_sync_q <= {clk_sync_q[1:0], bus.flash_clk};
            io_s1_q    <= bus.io_in;
            io_s2_q    <= io_s1_q;
        end
    end

    // Transaction decode: rises shift in command/address/mode, falls shift out data; csb high wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        quad_d  = quad_q;
        cont_d  = cont_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        out_d   = out_q;
        oe_d    = oe_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        if (csb) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            bcnt_d  = 3'd0;
            out_d   = 4'h0;
            oe_d    = 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = cont_q ? S_ADDR : S_CMD;
                    quad_d  = cont_q;
                    cnt_d   = 8'd0;
                end
                S_CMD: if (rise) begin
                    sr_d  = shin;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        cnt_d   = 8'd0;
                        state_d = (shin[7:0] == 8'h03 || shin[7:0] == 8'hEB) ? S_ADDR : S_IGN;
                        quad_d  = shin[7:0] == 8'hEB;
                        cont_d  = (shin[7:0] == 8'hFF) ? 1'b0 : cont_q;
                    end
                end
                S_ADDR: if (rise) begin
                    sr_d  = shin;
                    cnt_d = cnt_q + 8'd1;
                    if (addr_last) begin
                        cnt_d   = 8'd0;
                        addr_d  = shin[MEM_AW-1:0];
                        rd_d    = 1'b1;
                        state_d = quad_q ? S_MODE : S_DATA;
                    end
                end
                S_MODE: if (rise) begin
                    sr_d  = shin;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        cont_d  = shin[5:4] == 2'b10;
                        state_d = (DUMMY_QIO == 0) ? S_DATA : S_DUMMY;
                    end
                end
                S_DUMMY: if (rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: if (fall) begin
                    out_d  = quad_q ? byte_v[7:4] : {2'b00, byte_v[7], 1'b0};
                    oe_d   = quad_q ? 4'b1111 : 4'b0010;
                    sh_d   = quad_q ? {byte_v[3:0], 4'h0} : {byte_v[6:0], 1'b0};
                    bcnt_d = (bcnt_q == bcnt_last) ? 3'd0 : bcnt_q + 3'd1;
                    if (bcnt_q == 3'd0) begin
                        addr_d = addr_q + MEM_AW'(1);
                        rd_d   = 1'b1;
                    end
                end
                S_IGN: oe_d = 4'h0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; the prefetch buffer captures memory data one clock after the strobe
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            sr_q     <= 24'd0;
            quad_q   <= 1'b0;
            cont_q   <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            out_q    <= 4'h0;
            oe_q     <= 4'h0;
            sh_q     <= 8'd0;
            bcnt_q   <= 3'd0;
            rvalid_q <= 1'b0;
            buf_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            quad_q   <= quad_d;
            cont_q   <= cont_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            sh_q     <= sh_d;
            bcnt_q   <= bcnt_d;
            rvalid_q <= rd_q;
            buf_q    <= rvalid_q ? bus.mem_rdata : buf_q;
        end
    end

    assign bus.io_out    = out_q;
    assign bus.io_oe     = oe_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = rd_q;
    assign bus.cont_mode = cont_q;
    assign bus.active    = state_q != S_IDLE;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: table-driven flash reads with a byte scoreboard plus abort/ignore/reset sequences
module tb_qspi_flash_responder;
    localparam int AW = 12;
    localparam int H  = 8;

    typedef struct {
        logic        skip_cmd;
        logic [7:0]  cmd;
        logic        quad;
        logic [23:0] addr;
        logic [7:0]  mode;
        int          nbytes;
        logic [31:0] exp_data;
        logic        exp_cont;
    } vec_t;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    always #5 clock = ~clock;

    qspi_flash_responder_if #(.MEM_AW(AW)) bus();
    qspi_flash_responder #(.MEM_AW(AW), .DUMMY_QIO(4)) dut (
        .clock(clock),
        .resetb(resetb),
        .bus(bus)
    );

    logic [7:0] mem [0:4095];
    int         rd_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];
    vec_t       vecs[8];

    // Synchronous memory: data valid one clock after the strobe
    always @(posedge clock) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    always @(posedge clock) if (bus.mem_rd) rd_cnt <= rd_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (H) @(negedge clock);
    endtask

    // One flash_clk period: drive io in low phase, sample pads just before the rise
    task automatic fcycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
        bus.io_in = din;
        half();
        dout = bus.io_out;
        oe   = bus.io_oe;
        bus.flash_clk = 1'b1;
        half();
        bus.flash_clk = 1'b0;
    endtask

    task automatic ctrl_cycle(input logic [3:0] din, input string name);
        logic [3:0] d, oe;
        fcycle(din, d, oe);
        check(name, 32'(oe), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        for (int i = 7; i >= 0; i--) ctrl_cycle({3'b000, b[i]}, name);
    endtask

    task automatic start();
        bus.flash_csb = 1'b0;
        half();
    endtask

    task automatic stop();
        bus.flash_clk = 1'b0;
        bus.flash_csb = 1'b1;
        repeat (2 * H) @(negedge clock);
        check("idle_active", 32'(bus.active), 32'h0);
        check("idle_oe", 32'(bus.io_oe), 32'h0);
    endtask

    // abort_cycles >= 0 leaves the transaction open after that many data clocks
    task automatic run_vec(input vec_t v, input int abort_cycles);
        logic [3:0] d, oe, exp_oe;
        logic [7:0] got;
        start();
        if (!v.skip_cmd) send_byte(v.cmd, "cmd_oe");
        check("active", 32'(bus.active), 32'h1);
        if (v.quad) for (int i = 5; i >= 0; i--) ctrl_cycle(v.addr[4*i +: 4], "addr_oe");
        else for (int i = 23; i >= 0; i--) ctrl_cycle({3'b000, v.addr[i]}, "addr_oe");
        if (v.quad) begin
            ctrl_cycle(v.mode[7:4], "mode_oe");
            ctrl_cycle(v.mode[3:0], "mode_oe");
            for (int i = 0; i < 4; i++) ctrl_cycle(4'h0, "dummy_oe");
        end
        exp_oe = v.quad ? 4'hF : 4'h2;
        if (abort_cycles >= 0) begin
            for (int i = 0; i < abort_cycles; i++) begin
                fcycle(4'h0, d, oe);
                check("part_oe", 32'(oe), 32'(exp_oe));
            end
            return;
        end
        for (int n = 0; n < v.nbytes; n++) sb_q.push_back(v.exp_data[31 - 8*n -: 8]);
        for (int n = 0; n < v.nbytes; n++) begin
            got = 8'h00;
            for (int k = 0; k < (v.quad ? 2 : 8); k++) begin
                fcycle(4'h0, d, oe);
                check("data_oe", 32'(oe), 32'(exp_oe));
                got = v.quad ? {got[3:0], d} : {got[6:0], d[1]};
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL data: got %0h expected nothing", got);
            end else check("data", 32'(got), 32'(sb_q.pop_front()));
        end
        stop();
        check("cont_mode", 32'(bus.cont_mode), 32'(v.exp_cont));
    endtask

    initial begin
        int rd_base;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h010] = 8'hA5; mem[12'h011] = 8'h5A; mem[12'h012] = 8'h01; mem[12'h013] = 8'hFE;
        mem[12'h100] = 8'h12; mem[12'h101] = 8'h34;
        mem[12'h200] = 8'h5E; mem[12'h300] = 8'hC3;
        mem[12'hFFF] = 8'h77; mem[12'h000] = 8'h88;
        //           skip  cmd    quad  addr          mode   n  expected bytes  cont
        vecs[0] = '{1'b0, 8'h03, 1'b0, 24'h000010, 8'h00, 4, 32'hA55A01FE, 1'b0};
        vecs[1] = '{1'b0, 8'hEB, 1'b1, 24'h000100, 8'h00, 2, 32'h12340000, 1'b0};
        vecs[2] = '{1'b0, 8'hEB, 1'b1, 24'h000300, 8'h20, 1, 32'hC3000000, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 24'h000200, 8'h20, 1, 32'h5E000000, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 24'hFFFFFF, 8'hFF, 0, 32'h00000000, 1'b0};
        vecs[5] = '{1'b0, 8'h03, 1'b0, 24'h000FFF, 8'h00, 2, 32'h77880000, 1'b0};
        vecs[6] = '{1'b0, 8'hEB, 1'b1, 24'hABCFFF, 8'h10, 2, 32'h77880000, 1'b0};
        vecs[7] = '{1'b0, 8'h03, 1'b0, 24'h000011, 8'h00, 3, 32'h5A01FE00, 1'b0};
        bus.flash_csb = 1'b1;
        bus.flash_clk = 1'b0;
        bus.io_in     = 4'h0;
        repeat (3) @(negedge clock);
        check("rst_io_out", 32'(bus.io_out), 32'h0);
        check("rst_io_oe", 32'(bus.io_oe), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("rst_cont", 32'(bus.cont_mode), 32'h0);
        check("rst_active", 32'(bus.active), 32'h0);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 8; i++) run_vec(vecs[i], -1);
        // Unsupported command: 32 clocks with no drive and no memory access
        rd_base = rd_cnt;
        start();
        send_byte(8'h9F, "cmd_oe");
        for (int i = 0; i < 24; i++) ctrl_cycle(4'hF, "ign_oe");
        check("ign_active", 32'(bus.active), 32'h1);
        stop();
        check("ign_rd", 32'(rd_cnt - rd_base), 32'h0);
        // Mode-reset command lands in IGNORE with continuous mode off
        start();
        send_byte(8'hFF, "cmd_oe");
        ctrl_cycle(4'h0, "ff_oe");
        check("ff_active", 32'(bus.active), 32'h1);
        stop();
        check("ff_cont", 32'(bus.cont_mode), 32'h0);
        // Abort after 3 data bits, then a clean read
        run_vec(vecs[0], 3);
        bus.flash_clk = 1'b0;
        bus.flash_csb = 1'b1;
        repeat (4) @(negedge clock);
        check("abort_oe", 32'(bus.io_oe), 32'h0);
        half();
        check("abort_active", 32'(bus.active), 32'h0);
        run_vec(vecs[7], -1);
        // Continuous-mode read interrupted by reset mid-data
        run_vec(vecs[2], -1);
        run_vec(vecs[3], 1);
        check("pre_rst_cont", 32'(bus.cont_mode), 32'h1);
        check("pre_rst_active", 32'(bus.active), 32'h1);
        resetb = 1'b0;
        #1;
        check("arst_io_out", 32'(bus.io_out), 32'h0);
        check("arst_io_oe", 32'(bus.io_oe), 32'h0);
        check("arst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("arst_mem_rd", 32'(bus.mem_rd), 32'h0);
        check("arst_cont", 32'(bus.cont_mode), 32'h0);
        check("arst_active", 32'(bus.active), 32'h0);
        bus.flash_clk = 1'b0;
        bus.flash_csb = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_hold_oe", 32'(bus.io_oe), 32'h0);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        run_vec(vecs[0], -1);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable SPI/QSPI flash responder: the target side of the management SoC flash interface (flash_csb, flash_clk, flash_io0..3). It decodes read commands from the flash controller and serves bytes from a synchronous byte-wide memory port. It is used for FPGA bring-up and for standalone verification of the flash controller without a behavioural flash model. The bus is oversampled on the system clock; `flash_clk` must run at most clock/8.

## Interface

Parameters:
- MEM_AW, 12: byte-address width of the memory port; the received 24-bit address is truncated to this width.
- DUMMY_QIO, 4: dummy flash_clk cycles after the mode byte for command 0xEB.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetb  in  1  asynchronous active-low reset.
- flash_csb  in  1  chip select, active low.
- flash_clk  in  1  SPI clock, mode 0.
- io_in  in  4  pad inputs {io3,io2,io1,io0}.
- io_out  out  4  pad output data.
- io_oe  out  4  pad output enables, per bit.
- mem_addr  out  MEM_AW  read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid exactly 1 clock after mem_rd.
- cont_mode  out  1  continuous-read (XIP) mode latched.
- active  out  1  high while a transaction is decoded (state not IDLE).

## Operation

- Input conditioning:
  - flash_csb and flash_clk pass through 2-flop synchronizers.
  - io_in is delayed by the same 2 flops so that data and clock stay aligned.
  - Edge detect on the synchronized clock gives rise/fall pulses.
- Sampling: rise samples, fall drives (SPI mode 0). MSB first on every lane.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- Start of transaction (synchronized csb falls):
  - cont_mode=0: go to CMD.
  - cont_mode=1: go directly to ADDR in quad width; the command phase is skipped.
- CMD: 8 single-bit samples on io0. Decoding:
  - 0x03 → ADDR in single width.
  - 0xEB → ADDR in quad width.
  - 0xFF → clear cont_mode, then IGNORE.
  - 0xAB, 0xB9, anything else → IGNORE.
- ADDR: 24 bits, taking 24 clocks (single) or 6 clocks (quad).
  - On the completing rise: mem_addr = addr[MEM_AW-1:0] and mem_rd pulses.
  - Next state: 0x03 → DATA; quad → MODE.
- MODE: 2 quad clocks.
  - cont_mode is set if mode[5:4]==2'b10, otherwise cleared.
  - Then DUMMY for DUMMY_QIO clocks (counted on rises).
  - The completing rise of DUMMY enters DATA.
- DATA:
  - The fetched byte loads the shift register before the next fall.
  - mem_addr increments, wrapping modulo 2^MEM_AW, and mem_rd prefetches the next byte immediately.
  - Single mode: io1 is driven (io_oe=4'b0010), 8 falls per byte.
  - Quad mode: io_oe=4'b1111, 2 falls per byte, high nibble first.
  - DATA continues until csb rises.
- IGNORE: io_oe=0; stay until csb rises.
- Synchronized csb high in any state:
  - Next clock: state=IDLE, io_oe=0, all counters cleared.
  - cont_mode is retained.
  - An abort mid-byte discards the partial byte.
- Reset values: io_out=0, io_oe=0, mem_addr=0, mem_rd=0, cont_mode=0, active=0, state IDLE.

## Timing

- Rising or falling pad edge → rise/fall pulse after 3 clocks (2 sync + edge register).
- The first data bit drives on the first fall after the last address/dummy rise. The mem_rd → load path is ≤2 clocks, which is met because the flash_clk half-period is ≥4 clocks.
- io_out/io_oe update exactly 1 clock after the fall pulse.
- mem_rd is a single-cycle pulse, at most one per byte.
- csb and a clk edge in the same cycle: csb takes priority and the edge is ignored.
- Reset is asynchronous on assertion. Release is synchronous to clock via the existing flops; io_oe must be 0 throughout reset.

## Test plan

- 0x03, addr 0x000010, 4 bytes, mem[0x10..0x13]=A5 5A 01 FE → io1 returns A5 5A 01 FE; io_oe=4'b0010 during data only.
- 0xEB, addr 0x000100, mode 0x00, 4 dummy clocks, 2 bytes with mem=12 34 → nibbles 1,2,3,4 on io[3:0]; cont_mode stays 0.
- 0xEB with mode 0x20 → cont_mode=1.
  - Next transaction sends address 0x000200 directly, no command, and returns mem[0x200].
  - 0xFF clears cont_mode.
- Read at addr 0x000FFF (MEM_AW=12), 2 bytes → mem[0xFFF], then mem[0x000].
- csb raised after 3 data bits → io_oe=0 within 4 clocks. A following 0x03 read behaves normally.
- Command 0x9F, 32 clocks → io_oe stays 0, mem_rd never pulses. Assert resetb mid-DATA → all outputs at reset values immediately.
